// File: rtl/sim_halt_ctrl.sv
// ---------------------------------------------------------------------------
// sim_halt_ctrl
//   Core-side end of the simulation stop handshake. Watches the 2-wide retire
//   bus for the exit syscall (v0 == 10 or v0 == 17). On exit it freezes fetch,
//   waits for the store buffer to drain, then raises a sticky halted flag.
//   Keeps saturating cycle / retired-instruction counters and a watchdog that
//   stops runaway programs with exit code 8'hFF.
//
// Ports
//   clock             in   rising-edge clock
//   reset             in   asynchronous, active-high
//   retire_valid      in   [1:0] per-lane retire strobe, lane 0 is older
//   retire_is_syscall in   [1:0] per-lane syscall marker
//   v0_value          in   [31:0] committed $v0 in the retire cycle
//   a0_value          in   [31:0] committed $a0 in the retire cycle
//   sb_empty          in   store buffer has no pending stores
//   kill_lane1        out  combinational: drop lane-1 retire this cycle
//   stall_fetch       out  freeze the front end (registered)
//   halted            out  sticky: program finished or timed out
//   timeout           out  sticky: watchdog expired
//   exit_code         out  [7:0] exit status, valid when halted
//   cycle_count       out  [CNT_W-1:0] cycles since reset release
//   instr_count       out  [CNT_W-1:0] instructions retired
// ---------------------------------------------------------------------------
module sim_halt_ctrl #(
  parameter int CYCLE_LIMIT = 50000,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       retire_valid,
  input  logic [1:0]       retire_is_syscall,
  input  logic [31:0]      v0_value,
  input  logic [31:0]      a0_value,
  input  logic             sb_empty,
  output logic             kill_lane1,
  output logic             stall_fetch,
  output logic             halted,
  output logic             timeout,
  output logic [7:0]       exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_TIMEOUT} state_t;

  // Compared at 64 bits so a limit wider than the counter simply never fires.
  localparam logic [63:0] LIMIT_M1 = 64'(CYCLE_LIMIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [7:0]       exit_code_q, exit_code_d;
  logic             stall_q, stall_d;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;

  logic             exit_v0, exit0, exit1, wdog_hit;
  logic [1:0]       lanes_cnt;
  logic [CNT_W:0]   instr_sum;
  logic [CNT_W-1:0] instr_sat, cycle_inc;

  // Both lanes see the same committed $v0; the lane only qualifies the strobe.
  assign exit_v0 = (v0_value == 32'd10) || (v0_value == 32'd17);
  assign exit0   = retire_valid[0] & retire_is_syscall[0] & exit_v0;
  assign exit1   = retire_valid[1] & retire_is_syscall[1] & exit_v0;

  // An older-lane exit must squash the younger lane in the same cycle.
  assign kill_lane1 = (state_q == S_RUN) & exit0;

  assign wdog_hit = (64'(cycle_count_q) == LIMIT_M1);

  // Saturating arithmetic: one spare bit catches the carry out of the add.
  assign lanes_cnt = {1'b0, retire_valid[0]} + {1'b0, retire_valid[1] & ~kill_lane1};
  assign instr_sum = {1'b0, instr_count_q} + {{(CNT_W-1){1'b0}}, lanes_cnt};
  assign instr_sat = instr_sum[CNT_W] ? {CNT_W{1'b1}} : instr_sum[CNT_W-1:0];
  assign cycle_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    exit_code_d   = exit_code_q;
    stall_d       = stall_q;
    halted_d      = halted_q;
    timeout_d     = timeout_q;

    case (state_q)
      S_RUN: begin
        cycle_count_d = cycle_inc;
        instr_count_d = instr_sat;
        if (exit0 || exit1) begin
          exit_code_d = (v0_value == 32'd17) ? a0_value[7:0] : 8'h00;
          stall_d     = 1'b1;
          // A ready halt beats the watchdog on the same edge.
          if (sb_empty) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else if (wdog_hit) begin
            state_d     = S_TIMEOUT;
            halted_d    = 1'b1;
            timeout_d   = 1'b1;
            exit_code_d = 8'hFF;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (wdog_hit) begin
          state_d     = S_TIMEOUT;
          stall_d     = 1'b1;
          halted_d    = 1'b1;
          timeout_d   = 1'b1;
          exit_code_d = 8'hFF;
        end
      end

      S_DRAIN: begin
        cycle_count_d = cycle_inc;
        if (sb_empty) begin
          state_d  = S_HALTED;
          halted_d = 1'b1;
        end else if (wdog_hit) begin
          state_d     = S_TIMEOUT;
          halted_d    = 1'b1;
          timeout_d   = 1'b1;
          exit_code_d = 8'hFF;
        end
      end

      default: ;  // HALTED and TIMEOUT hold everything until reset
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      cycle_count_q <= '0;
      instr_count_q <= '0;
      exit_code_q   <= 8'h00;
      stall_q       <= 1'b0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
      exit_code_q   <= exit_code_d;
      stall_q       <= stall_d;
      halted_q      <= halted_d;
      timeout_q     <= timeout_d;
    end
  end

  assign stall_fetch = stall_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_sim_halt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sim_halt_ctrl
//   Directed bench for sim_halt_ctrl. Main instance runs with a 20-cycle
//   watchdog; a second narrow-counter instance exercises saturation.
//   Inputs change 1 ns after a rising edge; registered outputs are sampled
//   at the same point, combinational kill_lane1 just after inputs settle.
// ---------------------------------------------------------------------------
module tb_sim_halt_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  retire_valid = 2'b00;
  logic [1:0]  retire_is_syscall = 2'b00;
  logic [31:0] v0_value = '0;
  logic [31:0] a0_value = '0;
  logic        sb_empty = 1'b1;
  logic        kill_lane1, stall_fetch, halted, timeout;
  logic [7:0]  exit_code;
  logic [31:0] cycle_count, instr_count;

  // Saturation instance: 3-bit counters, watchdog effectively disabled.
  logic        rst2 = 1'b1;
  logic        k2, sf2, h2, t2;
  logic [7:0]  ec2;
  logic [2:0]  cc2, ic2;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  sim_halt_ctrl #(.CYCLE_LIMIT(20), .CNT_W(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .retire_valid     (retire_valid),
    .retire_is_syscall(retire_is_syscall),
    .v0_value         (v0_value),
    .a0_value         (a0_value),
    .sb_empty         (sb_empty),
    .kill_lane1       (kill_lane1),
    .stall_fetch      (stall_fetch),
    .halted           (halted),
    .timeout          (timeout),
    .exit_code        (exit_code),
    .cycle_count      (cycle_count),
    .instr_count      (instr_count)
  );

  sim_halt_ctrl #(.CYCLE_LIMIT(1000), .CNT_W(3)) dut_sat (
    .clock            (clock),
    .reset            (rst2),
    .retire_valid     (2'b11),
    .retire_is_syscall(2'b00),
    .v0_value         (32'd0),
    .a0_value         (32'd0),
    .sb_empty         (1'b1),
    .kill_lane1       (k2),
    .stall_fetch      (sf2),
    .halted           (h2),
    .timeout          (t2),
    .exit_code        (ec2),
    .cycle_count      (cc2),
    .instr_count      (ic2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] s,
                       input logic [31:0] v0, input logic [31:0] a0, input logic sb);
    retire_valid      = v;
    retire_is_syscall = s;
    v0_value          = v0;
    a0_value          = a0;
    sb_empty          = sb;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    drive(2'b00, 2'b00, 32'd0, 32'd0, 1'b1);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    #2;
    check("rst_halted", halted, 1'b0);
    check("rst_stall", stall_fetch, 1'b0);
    check("rst_cycle", cycle_count, 32'd0);
    do_reset();

    // ---- 1) five dual-retire RUN cycles ----
    drive(2'b11, 2'b00, 32'd0, 32'd0, 1'b1);
    repeat (5) tick();
    check("t1_cycle", cycle_count, 32'd5);
    check("t1_instr", instr_count, 32'd10);
    check("t1_halted", halted, 1'b0);
    check("t1_stall", stall_fetch, 1'b0);

    // ---- 2) lane-0 exit v0=10, sb empty -> straight to HALTED ----
    drive(2'b11, 2'b01, 32'd10, 32'h55, 1'b1);
    #1;
    check("t2_kill", kill_lane1, 1'b1);
    tick();
    check("t2_halted", halted, 1'b1);
    check("t2_exit", exit_code, 8'h00);
    check("t2_instr", instr_count, 32'd11);
    check("t2_cycle", cycle_count, 32'd6);
    check("t2_stall", stall_fetch, 1'b1);
    check("t2_tmo", timeout, 1'b0);
    check("t2_kill_halted", kill_lane1, 1'b0);
    tick();
    check("t2_cycle_frozen", cycle_count, 32'd6);
    check("t2_instr_frozen", instr_count, 32'd11);

    // ---- 3) lane-1 exit v0=17, store buffer busy 3 cycles ----
    do_reset();
    drive(2'b11, 2'b10, 32'd17, 32'h12345642, 1'b0);
    #1;
    check("t3_kill", kill_lane1, 1'b0);
    tick();
    check("t3_stall", stall_fetch, 1'b1);
    check("t3_halted0", halted, 1'b0);
    check("t3_instr", instr_count, 32'd2);
    check("t3_exit_latched", exit_code, 8'h42);
    drive(2'b11, 2'b00, 32'd0, 32'd0, 1'b0);
    repeat (2) tick();
    check("t3_drain_instr", instr_count, 32'd2);
    check("t3_drain_cycle", cycle_count, 32'd3);
    check("t3_drain_halted", halted, 1'b0);
    drive(2'b11, 2'b00, 32'd0, 32'd0, 1'b1);
    tick();
    check("t3_halted", halted, 1'b1);
    check("t3_exit", exit_code, 8'h42);
    check("t3_cycle", cycle_count, 32'd4);

    // ---- 4) non-exit syscall is an ordinary instruction ----
    do_reset();
    drive(2'b01, 2'b01, 32'd4, 32'd0, 1'b1);
    tick();
    check("t4_instr", instr_count, 32'd1);
    check("t4_stall", stall_fetch, 1'b0);
    check("t4_halted", halted, 1'b0);
    drive(2'b11, 2'b01, 32'd4, 32'd0, 1'b1);
    #1;
    check("t4_kill", kill_lane1, 1'b0);
    tick();
    check("t4_instr2", instr_count, 32'd3);

    // ---- 6) reset asserted mid-DRAIN between edges ----
    do_reset();
    drive(2'b11, 2'b01, 32'd10, 32'd0, 1'b0);
    tick();
    check("t6_drain_stall", stall_fetch, 1'b1);
    drive(2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("t6_stall", stall_fetch, 1'b0);
    check("t6_halted", halted, 1'b0);
    check("t6_cycle", cycle_count, 32'd0);
    check("t6_instr", instr_count, 32'd0);
    check("t6_exit", exit_code, 8'h00);
    check("t6_kill", kill_lane1, 1'b0);
    #2;
    reset = 1'b0;
    drive(2'b11, 2'b00, 32'd0, 32'd0, 1'b1);
    tick();
    check("t6_run_instr", instr_count, 32'd2);
    check("t6_run_stall", stall_fetch, 1'b0);

    // ---- 5) watchdog fires on edge 20 ----
    do_reset();
    drive(2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    repeat (19) tick();
    check("t5_pre_cycle", cycle_count, 32'd19);
    check("t5_pre_tmo", timeout, 1'b0);
    tick();
    check("t5_tmo", timeout, 1'b1);
    check("t5_halted", halted, 1'b1);
    check("t5_exit", exit_code, 8'hFF);
    check("t5_cycle", cycle_count, 32'd20);
    check("t5_stall", stall_fetch, 1'b1);
    repeat (3) tick();
    check("t5_cycle_frozen", cycle_count, 32'd20);

    // ---- 5b) exit + sb_empty on the watchdog edge: halt wins ----
    do_reset();
    drive(2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    repeat (19) tick();
    drive(2'b01, 2'b01, 32'd17, 32'h07, 1'b1);
    tick();
    check("t5b_halted", halted, 1'b1);
    check("t5b_tmo", timeout, 1'b0);
    check("t5b_exit", exit_code, 8'h07);
    check("t5b_instr", instr_count, 32'd1);

    // ---- 5c) watchdog expires while draining ----
    do_reset();
    drive(2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    repeat (18) tick();
    drive(2'b11, 2'b10, 32'd10, 32'd0, 1'b0);
    tick();
    check("t5c_drain_halted", halted, 1'b0);
    drive(2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    check("t5c_tmo", timeout, 1'b1);
    check("t5c_exit", exit_code, 8'hFF);
    check("t5c_instr", instr_count, 32'd2);

    // ---- counter saturation on the 3-bit instance ----
    @(negedge clock);
    rst2 = 1'b0;
    repeat (10) tick();
    check("sat_cycle", cc2, 3'd7);
    check("sat_instr", ic2, 3'd7);
    check("sat_halted", h2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
